// File: rtl/mmio_pkg.sv
// Shared constants for the memory-stage MMIO controller: I/O region select,
// register offsets and the TX holding-register state encoding.
package mmio_pkg;

  localparam logic [3:0] IO_NIBBLE = 4'b1000;

  localparam logic [7:0] UART_CTRL = 8'h00;
  localparam logic [7:0] UART_RX   = 8'h04;
  localparam logic [7:0] UART_TX   = 8'h08;
  localparam logic [7:0] CYC_CNT   = 8'h10;
  localparam logic [7:0] INST_CNT  = 8'h14;
  localparam logic [7:0] CNT_RST   = 8'h18;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/io_counter.sv
// 32-bit wrapping counter with increment enable and synchronous clear;
// clear takes priority over increment.
module io_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: UART status/data/TX registers and the
// cycle/instruction performance counters, with one-cycle registered load data.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter logic [3:0] IO_NIBBLE = mmio_pkg::IO_NIBBLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] addr,
  input  logic             mem_write,
  input  logic             mem_read,
  input  logic [WIDTH-1:0] wdata,
  input  logic             instr_retire,
  output logic [WIDTH-1:0] io_rdata,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);

  logic             sel;
  logic [7:0]       offset;
  logic             rd_en;
  logic             wr_en;
  logic             cnt_clr;
  logic             tx_load;
  logic [31:0]      cyc_count;
  logic [31:0]      inst_count;
  logic [WIDTH-1:0] rd_mux;
  tx_state_t        state_q;
  tx_state_t        state_d;

  assign sel     = (addr[WIDTH-1 -: 4] == IO_NIBBLE);
  assign offset  = addr[7:0];
  assign rd_en   = sel & mem_read;
  assign wr_en   = sel & mem_write;
  assign cnt_clr = wr_en & (offset == CNT_RST);

  assign rx_ready = rd_en & (offset == UART_RX) & rx_valid;

  io_counter u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .clr   (cnt_clr),
    .count (cyc_count)
  );

  io_counter u_inst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_retire),
    .clr   (cnt_clr),
    .count (inst_count)
  );

  // TX holding register: stores landing while a byte is pending are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_load  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (wr_en && (offset == UART_TX)) begin
          tx_load = 1'b1;
          state_d = TX_PEND;
        end
      end
      TX_PEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= '0;
    end else if (tx_load) begin
      tx_data <= wdata[7:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      UART_CTRL: rd_mux[1:0]  = {rx_valid, ~tx_valid};
      UART_RX:   rd_mux[7:0]  = rx_data;
      CYC_CNT:   rd_mux[31:0] = cyc_count;
      INST_CNT:  rd_mux[31:0] = inst_count;
      default:   rd_mux       = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata <= '0;
    end else if (rd_en) begin
      io_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: load results go through a scoreboard
// queue filled when a read is issued and drained when io_rdata is due.
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] wdata = '0;
  logic        instr_retire = 1'b0;
  logic [31:0] io_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] exp_q[$];

  mmio_ctrl #(.WIDTH(32), .IO_NIBBLE(4'b1000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .wdata        (wdata),
    .instr_retire (instr_retire),
    .io_rdata     (io_rdata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the load edge.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                         input logic exp_pop);
    exp_q.push_back(exp);
    addr     = a;
    mem_read = 1'b1;
    #1;
    check_val({tag, "_pop"}, {31'b0, rx_ready}, {31'b0, exp_pop});
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    check_val({tag, "_nopop"}, {31'b0, rx_ready}, 32'h0);
    check_val(tag, io_rdata, exp_q.pop_front());
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_val("rst_rdata", io_rdata, 32'h0);
    check_val("rst_txdata", {24'b0, tx_data}, 32'h0);
    check_val("rst_txvalid", {31'b0, tx_valid}, 32'h0);
    check_val("rst_rxready", {31'b0, rx_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_read("status_idle", 32'h8000_0000, 32'h1, 1'b0);
    do_read("unlisted", 32'h8000_000C, 32'h0, 1'b0);

    // TX store held off for three cycles, second store dropped
    do_write(32'h8000_0008, 32'h41);
    check_val("tx_valid_c1", {31'b0, tx_valid}, 32'h1);
    check_val("tx_data", {24'b0, tx_data}, 32'h41);
    do_write(32'h8000_0008, 32'h42);
    check_val("tx_valid_c2", {31'b0, tx_valid}, 32'h1);
    check_val("tx_drop", {24'b0, tx_data}, 32'h41);
    @(negedge clk);
    check_val("tx_valid_c3", {31'b0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check_val("tx_done", {31'b0, tx_valid}, 32'h0);
    check_val("tx_data_keep", {24'b0, tx_data}, 32'h41);
    do_read("status_after_tx", 32'h8000_0000, 32'h1, 1'b0);
    check_val("tx_no_resend", {31'b0, tx_valid}, 32'h0);

    // RX pop
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    do_read("status_rx", 32'h8000_0000, 32'h3, 1'b0);
    do_read("rx_read", 32'h8000_0004, 32'h5A, 1'b1);
    rx_valid = 1'b0;
    do_read("rx_stale", 32'h8000_0004, 32'h5A, 1'b0);

    // io_rdata holds on a non-I/O read
    addr     = 32'h0000_0010;
    mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    check_val("hold", io_rdata, 32'h5A);

    // counters relative to reset release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      instr_retire = (i < 40);
      @(negedge clk);
    end
    instr_retire = 1'b0;
    do_read("cyc_100", 32'h8000_0010, 32'd100, 1'b0);
    do_read("inst_40", 32'h8000_0014, 32'd40, 1'b0);

    // clear coincident with retire: clear wins
    instr_retire = 1'b1;
    do_write(32'h8000_0018, 32'hDEAD_BEEF);
    instr_retire = 1'b0;
    do_read("cyc_clr", 32'h8000_0010, 32'h0, 1'b0);
    do_read("inst_clr", 32'h8000_0014, 32'h0, 1'b0);

    // cycle counter wrap
    force dut.u_cyc_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_cyc_cnt.count;
    repeat (3) @(negedge clk);
    do_read("cyc_wrap", 32'h8000_0010, 32'h1, 1'b0);

    // non-I/O store does not reach TX
    do_write(32'h0000_0008, 32'h55);
    check_val("nonio_tx", {31'b0, tx_valid}, 32'h0);

    // reset while pending abandons the byte immediately
    do_write(32'h8000_0008, 32'h77);
    check_val("pend_before_rst", {31'b0, tx_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_txvalid_async", {31'b0, tx_valid}, 32'h0);
    check_val("rst_txdata_async", {24'b0, tx_data}, 32'h0);
    check_val("rst_rdata_async", io_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_txvalid", {31'b0, tx_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Memory-mapped I/O controller in the memory stage, beside the data/instruction memory write-mask logic. It decodes the I/O address region (address top nibble `4'b1000`) and services loads/stores to the UART control/data registers and the cycle/instruction performance counters. It drives the UART's ready/valid ports and returns load data registered, so it has the same one-cycle latency as synchronous BRAM reads.

## Interface
Parameters:
- `WIDTH`, 32, data/address width
- `IO_NIBBLE`, 4'b1000, value of `addr[31:28]` that selects this block

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `addr`  in  WIDTH  ALU result (byte address)
- `mem_write`  in  1  store in memory stage
- `mem_read`  in  1  load in memory stage
- `wdata`  in  WIDTH  store data, already aligned
- `instr_retire`  in  1  one pulse per retired instruction
- `io_rdata`  out  WIDTH  registered load data
- `tx_data`  out  8  byte to UART transmitter
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  transmitter accepts byte
- `rx_data`  in  8  byte from UART receiver
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  pop received byte

## Operation
- Select: `sel = (addr[31:28] == IO_NIBBLE)`. Access offset is `addr[7:0]`. Unlisted offsets read 0 and ignore writes.
- Register map:
  - 0x00 R: `{30'b0, rx_valid, ~tx_valid}`
  - 0x04 R: `{24'b0, rx_data}`; if `rx_valid`, pulse `rx_ready` for one cycle
  - 0x08 W: load `wdata[7:0]` into the TX holding register
  - 0x10 R: cycle counter
  - 0x14 R: instruction counter
  - 0x18 W: any value clears both counters
- TX holding FSM:
  - IDLE: `tx_valid=0`. On a store to 0x08, latch `tx_data` and go to PEND.
  - PEND: `tx_valid=1`. When `tx_ready=1`, go to IDLE.
  - A store to 0x08 while in PEND is dropped; software polls bit 0 first.
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0.
  - Cycle counter increments every cycle.
  - Instruction counter increments when `instr_retire=1`.
- RX pop:
  - `rx_ready` is combinational: `sel & mem_read & offset==0x04 & rx_valid`.
  - Reading 0x04 with `rx_valid=0` returns the stale byte and produces no pop.
- If both `mem_read` and `mem_write` are set, the write takes effect and the read data is still returned.

## Timing
- Reset values: `io_rdata=0`, `tx_data=0`, `tx_valid=0`, both counters 0, FSM in IDLE. `rx_ready` is 0 whenever there is no read access.
- Load latency: `io_rdata` holds the addressed value one cycle after `mem_read`. It reflects pre-edge state; for example, a 0x10 read returns the count at the request edge.
- `io_rdata` holds its value when there is no I/O read.
- TX: a store at edge N gives `tx_valid=1` after edge N. A handshake at edge M (`tx_valid & tx_ready`) gives `tx_valid=0` after edge M.
- The earliest the status bit shows TX idle again is one cycle after the handshake.
- Counter clear (0x18) in the same cycle as an increment: clear wins, and the counter reads 0 on the next cycle.
- Asserting `rst_n` low mid-operation immediately forces all reset values, including abandoning a pending TX byte. No handshake completes while reset is asserted.

## Structure
- Shared package `mmio_pkg`: `IO_NIBBLE`, offsets `UART_CTRL=8'h00`, `UART_RX=8'h04`, `UART_TX=8'h08`, `CYC_CNT=8'h10`, `INST_CNT=8'h14`, `CNT_RST=8'h18`, and the TX FSM state encoding.
- One sub-module, `io_counter`: 32-bit wrap counter with `inc` and synchronous `clr` (clr has priority). It is instantiated twice.

## Test plan
- Reset, then read 0x00 with `rx_valid=0`, `tx_ready=0` -> `io_rdata=32'h1` the next cycle; all outputs 0 during reset.
- Store 0x41 to 0x80000008 with `tx_ready` held low for 3 cycles, plus a second store of 0x42 -> `tx_data=0x41`, `tx_valid` high for 3 cycles, then cleared one cycle after `tx_ready=1`; 0x42 is never sent.
- `rx_valid=1`, `rx_data=0x5A`, load 0x80000004 -> `rx_ready` pulses exactly one cycle and `io_rdata=32'h5A` next cycle. Repeating with `rx_valid=0` -> no pulse.
- Run 100 cycles with 40 `instr_retire` pulses, then read 0x10 and 0x14 -> 100 and 40 (relative to reset release).
- Preload the counter near wrap (force to 0xFFFFFFFE), run 3 cycles -> reads 0x00000001. A store to 0x18 coincident with `instr_retire` -> both counters read 0.
- Access address 0x0000_0008 (non-I/O nibble) with a store -> `tx_valid` stays 0. Assert `rst_n` low while in PEND -> `tx_valid` drops immediately.
